// File: rtl/pwm_pkg.sv
// pwm_pkg: types and defaults shared by the PWM generator and capture.
// CNT_W default is common so settings and measurements compare directly.
package pwm_pkg;

  localparam int PWM_CNT_W       = 16;
  localparam int PWM_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_HIGH,
    ST_LOW
  } cap_state_t;

endpackage

// File: rtl/sync_edge.sv
// sync_edge: async-reset synchroniser chain plus delay flop,
// giving the synchronised level and one-cycle rise/fall pulses.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_dly;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_s    = r_sync[SYNC_STAGES-1];
  assign o_rise = o_s & ~r_dly;
  assign o_fall = ~o_s & r_dly;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of each complete PWM
// cycle in clk cycles, with valid and timeout strobes.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = PWM_CNT_W,
  parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam int               WARM_W  = $clog2(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(SYNC_STAGES);

  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  logic             w_sat;
  logic             w_warm;
  cap_state_t       r_state;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_hi;
  logic [WARM_W-1:0] r_warm;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst   (rst),
    .i_d   (pwm_in),
    .o_s   (w_s),
    .o_rise(w_rise),
    .o_fall(w_fall)
  );

  // The chain holds reset zeros until it has refilled; trusting s
  // earlier would mistake an input held high for a low-then-rise.
  assign w_warm = (r_warm == WARM_DONE);
  assign w_sat  = (r_per == CNT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_per      <= '0;
      r_hi       <= '0;
      r_warm     <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      timeout    <= 1'b0;
      if (!w_warm)
        r_warm <= r_warm + 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          if (w_warm && !w_s)
            r_state <= ST_ARM;
        end
        ST_ARM: begin
          if (w_rise) begin
            r_per   <= CNT_ONE;
            r_hi    <= CNT_ONE;
            r_state <= ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (w_sat) begin
            timeout <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_per <= r_per + CNT_ONE;
            if (w_fall)
              r_state <= ST_LOW;
            else
              r_hi <= r_hi + CNT_ONE;
          end
        end
        ST_LOW: begin
          if (w_rise) begin
            period_out <= r_per;
            high_out   <= r_hi;
            meas_valid <= 1'b1;
            r_per      <= CNT_ONE;
            r_hi       <= CNT_ONE;
            r_state    <= ST_HIGH;
          end else if (w_sat) begin
            timeout <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_per <= r_per + CNT_ONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and random PWM stimulus against an
// edge-timestamp reference model, for CNT_W = 16 and CNT_W = 6.
module tb_pwm_capture;

  localparam int SYNC = 2;
  localparam int MAX16 = 65535;
  localparam int MAX6 = 63;

  typedef struct {
    bit armed;
    bit meas;
    bit in_high;
    bit prev;
    int k;
    int t_rise;
    int hi;
    int per_o;
    int hi_o;
  } mdl_t;

  typedef struct {
    bit v;
    bit t;
    int per;
    int hi;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pwm_in = 1'b0;
  logic [15:0] p16, h16;
  logic        v16, t16;
  logic [5:0]  p6, h6;
  logic        v6, t6;

  int   n_chk = 0;
  int   n_err = 0;
  int   n_to16 = 0;
  int   n_to6 = 0;
  mdl_t m16, m6;
  res_t q16[$];
  res_t q6[$];
  res_t rep16[$];
  res_t rep6[$];

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(16), .SYNC_STAGES(SYNC)) u_dut16 (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .period_out(p16), .high_out(h16),
    .meas_valid(v16), .timeout(t16)
  );

  pwm_capture #(.CNT_W(6), .SYNC_STAGES(SYNC)) u_dut6 (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .period_out(p6), .high_out(h6),
    .meas_valid(v6), .timeout(t6)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: measurement = distance between timestamps of
  // synchronised-sample edges; timeout when a cycle outlives maxv.
  task automatic mdl_step(input mdl_t mi, input bit x, input int maxv,
                          output mdl_t mo, output res_t r);
    bit rise, fall;
    int age;
    mo = mi;
    mo.k = mi.k + 1;
    rise = x && !mi.prev;
    fall = !x && mi.prev;
    r.v = 1'b0;
    r.t = 1'b0;
    if (!mo.armed) begin
      if (!x) mo.armed = 1'b1;
    end else if (!mo.meas) begin
      if (rise) begin
        mo.meas = 1'b1;
        mo.in_high = 1'b1;
        mo.t_rise = mo.k;
      end
    end else begin
      age = mo.k - mo.t_rise;
      if (rise) begin
        mo.per_o = age;
        mo.hi_o = mo.hi;
        r.v = 1'b1;
        mo.t_rise = mo.k;
        mo.in_high = 1'b1;
      end else if (age == maxv) begin
        r.t = 1'b1;
        mo.meas = 1'b0;
        mo.armed = 1'b0;
      end else if (mo.in_high && fall) begin
        mo.hi = age;
        mo.in_high = 1'b0;
      end
    end
    mo.prev = x;
    r.per = mo.per_o;
    r.hi = mo.hi_o;
  endtask

  always @(posedge clk or negedge rst) begin : model
    mdl_t mn;
    res_t r;
    if (!rst) begin
      m16 = '{default: 0};
      m6 = '{default: 0};
      q16.delete();
      q6.delete();
      for (int i = 0; i < SYNC; i++) begin
        q16.push_back('{default: 0});
        q6.push_back('{default: 0});
      end
    end else begin
      mdl_step(m16, pwm_in, MAX16, mn, r);
      m16 = mn;
      q16.push_back(r);
      mdl_step(m6, pwm_in, MAX6, mn, r);
      m6 = mn;
      q6.push_back(r);
    end
  end

  always @(negedge clk) begin : monitor
    res_t e;
    if (rst) begin
      if (q16.size() > SYNC) begin
        e = q16.pop_front();
        chk("valid16", v16, e.v);
        chk("tmo16", t16, e.t);
        chk("period16", p16, e.per);
        chk("high16", h16, e.hi);
      end
      if (q6.size() > SYNC) begin
        e = q6.pop_front();
        chk("valid6", v6, e.v);
        chk("tmo6", t6, e.t);
        chk("period6", p6, e.per);
        chk("high6", h6, e.hi);
      end
      if (v16) rep16.push_back('{1'b1, 1'b0, int'(p16), int'(h16)});
      if (v6) rep6.push_back('{1'b1, 1'b0, int'(p6), int'(h6)});
      if (t16) n_to16++;
      if (t6) n_to6++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wave(input int per, input int hi);
    pwm_in = 1'b1;
    repeat (hi) tick();
    pwm_in = 1'b0;
    repeat (per - hi) tick();
  endtask

  task automatic close_rise();
    wave(12, 6);
  endtask

  task automatic do_reset(input bit lvl);
    pwm_in = lvl;
    rst = 1'b0;
    #1;
    chk("rst_p16", p16, 0);
    chk("rst_h16", h16, 0);
    chk("rst_v16", v16, 0);
    chk("rst_t16", t16, 0);
    chk("rst_p6", p6, 0);
    chk("rst_h6", h6, 0);
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int lat;
    int n;
    int to6_0;
    int to16_0;
    int per;
    int hi;

    // reset and 10/5 square wave
    rst = 1'b0;
    pwm_in = 1'b0;
    repeat (3) tick();
    chk("init_p16", p16, 0);
    chk("init_v16", v16, 0);
    rst = 1'b1;
    repeat (5) tick();
    rep16.delete();
    repeat (4) wave(10, 5);
    chk("sq_count", rep16.size(), 3);
    pwm_in = 1'b1;
    lat = 0;
    n = 0;
    while (n < 5 && lat == 0) begin
      tick();
      n++;
      if (v16) lat = n;
    end
    chk("sq_latency", lat, SYNC + 1);
    repeat (5 - n) tick();
    pwm_in = 1'b0;
    repeat (5) tick();
    chk("sq_count4", rep16.size(), 4);
    if (rep16.size() == 4) begin
      chk("sq_per", rep16[3].per, 10);
      chk("sq_hi", rep16[3].hi, 5);
    end

    // duty sweep at period 20
    rep16.delete();
    wave(20, 1);
    wave(20, 7);
    wave(20, 19);
    close_rise();
    chk("sweep_count", rep16.size(), 4);
    if (rep16.size() == 4) begin
      chk("sweep_hi1", rep16[1].hi, 1);
      chk("sweep_hi7", rep16[2].hi, 7);
      chk("sweep_hi19", rep16[3].hi, 19);
      chk("sweep_per", rep16[3].per, 20);
    end

    // input high across reset release
    do_reset(1'b1);
    repeat (20) tick();
    rep16.delete();
    repeat (3) wave(8, 3);
    close_rise();
    chk("hi_rst_count", rep16.size(), 2);
    if (rep16.size() > 0) begin
      chk("hi_rst_per", rep16[0].per, 8);
      chk("hi_rst_hi", rep16[0].hi, 3);
    end

    // saturation on the narrow instance
    repeat (2) wave(12, 4);
    to6_0 = n_to6;
    to16_0 = n_to16;
    pwm_in = 1'b1;
    lat = 0;
    n = 0;
    while (n < 200 && lat == 0) begin
      tick();
      n++;
      if (n == 4) pwm_in = 1'b0;
      if (t6) lat = n;
    end
    chk("tmo_latency", lat, SYNC + 1 + MAX6);
    chk("tmo_hold_per", p6, 12);
    chk("tmo_hold_hi", h6, 4);
    repeat (20) tick();
    chk("tmo6_once", n_to6 - to6_0, 1);
    chk("tmo16_none", n_to16 - to16_0, 0);
    repeat (3) wave(9, 2);
    close_rise();
    if (rep6.size() >= 2) begin
      chk("tmo_next_per", rep6[rep6.size()-2].per, 9);
      chk("tmo_next_hi", rep6[rep6.size()-2].hi, 2);
    end else begin
      chk("tmo_next_cnt", rep6.size(), 2);
    end

    // reset in the middle of a low phase
    repeat (2) wave(12, 4);
    pwm_in = 1'b1;
    repeat (4) tick();
    pwm_in = 1'b0;
    repeat (3) tick();
    chk("pre_rst_per", p16, 12);
    do_reset(1'b0);
    repeat (4) tick();
    rep16.delete();
    wave(7, 2);
    chk("post_rst_none", rep16.size(), 0);
    wave(7, 2);
    close_rise();
    chk("post_rst_count", rep16.size(), 2);
    if (rep16.size() > 0) begin
      chk("post_rst_per", rep16[0].per, 7);
      chk("post_rst_hi", rep16[0].hi, 2);
    end

    // period change between consecutive cycles
    rep16.delete();
    wave(10, 3);
    wave(16, 9);
    close_rise();
    chk("chg_count", rep16.size(), 3);
    if (rep16.size() == 3) begin
      chk("chg_per10", rep16[1].per, 10);
      chk("chg_hi3", rep16[1].hi, 3);
      chk("chg_per16", rep16[2].per, 16);
      chk("chg_hi9", rep16[2].hi, 9);
    end

    // random waves, occasional resets, some past the 6-bit limit
    for (int i = 0; i < 40; i++) begin
      per = $urandom_range(70, 2);
      hi = $urandom_range(per - 1, 1);
      if ($urandom_range(9, 0) == 0)
        do_reset(1'($urandom_range(1, 0)));
      wave(per, hi);
    end
    pwm_in = 1'b0;
    repeat (80) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
